uvmt_axil_st_rsp_mem: RTL and testbench
=======================================

// Module: uvmt_axil_st_rsp_mem
// PURPOSE
//  Memory-backed completer (responder) for the self-test bench's APB-style bus (paddr/psel/penable/pwrite/
//  pwdata -> pready/prdata/pslverr). Sits behind the DUT wrapper on the slave side and answers every transfer
//  with programmable wait states. Flags out-of-range and misaligned accesses with pslverr.
//  Gives the master agent a cycle-accurate, self-consistent target for read-after-write checking.
// PARAMETERS
//  ADDR_WIDTH  32      paddr width (bits)
//  DATA_WIDTH  32      pwdata/prdata width; must be 8/16/32/64
//  DEPTH       256     number of DATA_WIDTH words; power of 2
//  BASE_ADDR   'h0     byte address of word 0; must be DEPTH*DATA_WIDTH/8 aligned
//  WAIT_WIDTH  4       width of wait_cycles input
// PORTS
//  clk          in   1            bus clock; all logic on rising edge
//  reset_n      in   1            asynchronous, active-low reset
//  wait_cycles  in   WAIT_WIDTH   wait states per transfer; sampled in setup cycle
//  paddr        in   ADDR_WIDTH   byte address
//  psel         in   1            select
//  penable      in   1            access phase
//  pwrite       in   1            1=write, 0=read
//  pwdata       in   DATA_WIDTH   write data
//  pready       out  1            transfer complete
//  prdata       out  DATA_WIDTH   read data, valid when pready & ~pwrite & ~pslverr
//  pslverr      out  1            error response, valid only when pready
// BEHAVIOUR
//  Reset: state=IDLE, wait counter=0, all memory words=0; pready=0, prdata=0, pslverr=0 (async assert, sync deassert).
//  FSM: IDLE, ACCESS. Outputs are combinational from registered state/counter/captured address.
//   IDLE:   psel & ~penable (setup) -> ACCESS; capture paddr, pwrite, cnt<=wait_cycles, err<=addr_err.
//           psel & penable without prior setup -> ignored, stay IDLE (protocol violation; no response).
//   ACCESS: ~psel -> IDLE, abort: no write, no response.
//           psel & cnt!=0 -> cnt<=cnt-1, pready=0.
//           psel & cnt==0 -> pready=1 this cycle, pslverr=err; -> IDLE next cycle.
//  Latency: completion in access cycle wait_cycles+1. wait_cycles=0 gives the minimum 2-cycle transfer.
//  addr_err: paddr<BASE_ADDR, or paddr>=BASE_ADDR+DEPTH*DATA_WIDTH/8, or paddr[log2(DATA_WIDTH/8)-1:0]!=0.
//  Word index = (paddr_q-BASE_ADDR)>>log2(DATA_WIDTH/8); only low log2(DEPTH) bits used.
//  Write: the full word is committed on the rising edge ending the pready=1 cycle, if pwrite_q & ~err.
//   Data is pwdata sampled in that cycle. Errored writes leave memory untouched.
//  Read: prdata=mem[idx] when pready & ~pwrite_q & ~err; otherwise prdata=0.
//  paddr/pwrite changes after setup are ignored; captured values rule.
//  Back-to-back: a new setup may start the cycle after completion (IDLE cycle), giving one transfer per 2+wait cycles.
//  wait_cycles changes mid-transfer have no effect on the current transfer.
//  Reset mid-transfer: FSM to IDLE, pready drops immediately, pending write discarded, memory cleared.
// STRUCTURE
//  Package uvmt_axil_st_pkg holds: typedef enum logic {IDLE, ACCESS} uvmt_axil_st_rsp_state_t and
//   localparams for bytes-per-word and address-range helpers.
//  Sub-module uvmt_axil_st_rsp_regfile: DEPTH x DATA_WIDTH array, async-reset clear, 1 write port and
//   1 combinational read port.
//  This module holds the FSM, wait counter, address decode and error logic.
// TESTING
//  1 wait=0, write 'hDEADBEEF @'h10 then read 'h10 -> pready in 1st access cycle each; prdata='hDEADBEEF, pslverr=0.
//  2 wait=3, read 'h0 after reset -> pready low 3 access cycles, high on 4th; prdata=0.
//  3 write @BASE+DEPTH*4 ('h400) and @'h2 (misaligned) -> pready=1, pslverr=1; re-read 'h0..'h3FC unchanged.
//  4 wait=5, write 'h1234 @'h20, psel dropped in 2nd access cycle -> no pready; read 'h20 returns 0.
//  5 write 'hA5A5A5A5 @'h3FC then immediately read 'h3FC, no idle gap, wait=0 -> read returns 'hA5A5A5A5.
//  6 reset_n pulsed low in the 2nd wait cycle of a write -> pready=0 at once; after release, all reads return 0.

Source files
------------

// File: rtl/uvmt_axil_st_pkg.sv
// Shared types and address helpers for the self-test bus responder.
package uvmt_axil_st_pkg;

    typedef enum logic {IDLE, ACCESS} uvmt_axil_st_rsp_state_t;

    localparam int BITS_PER_BYTE = 8;

    function automatic int bytes_per_word(input int data_width);
        return data_width / BITS_PER_BYTE;
    endfunction

    function automatic int byte_offset_bits(input int data_width);
        return $clog2(data_width / BITS_PER_BYTE);
    endfunction

    function automatic int span_bytes(input int depth, input int data_width);
        return depth * bytes_per_word(data_width);
    endfunction

endpackage

// File: rtl/uvmt_axil_st_rsp_regfile.sv
// Word-wide register file: one write port, one combinational read port, cleared by reset.
module uvmt_axil_st_rsp_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int IDX_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] words [DEPTH];

    // Each word owns its register so the whole array can clear in one reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [DATA_WIDTH-1:0] word_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    word_reg <= '0;
                end else if (we && (waddr == IDX_WIDTH'(gi))) begin
                    word_reg <= wdata;
                end
            end

            assign words[gi] = word_reg;
        end
    endgenerate

    assign rdata = words[raddr];

endmodule

// File: rtl/uvmt_axil_st_rsp_mem.sv
// Memory-backed APB-style completer with programmable wait states and range/alignment errors.
module uvmt_axil_st_rsp_mem
    import uvmt_axil_st_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    WAIT_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WAIT_WIDTH-1:0] wait_cycles,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr
);

    localparam int IDX_WIDTH = $clog2(DEPTH);
    localparam int BYTES     = bytes_per_word(DATA_WIDTH);
    localparam int OFF_BITS  = byte_offset_bits(DATA_WIDTH);

    // One extra bit so the end address of a window at the top of the map does not wrap.
    localparam logic [ADDR_WIDTH:0]   END_ADDR   = {1'b0, BASE_ADDR}
                                                 + (ADDR_WIDTH+1)'(span_bytes(DEPTH, DATA_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);

    uvmt_axil_st_rsp_state_t state_reg, state_next;
    logic [WAIT_WIDTH-1:0]   cnt_reg, cnt_next;
    logic [IDX_WIDTH-1:0]    idx_reg, idx_next;
    logic                    write_reg, write_next;
    logic                    err_reg, err_next;

    logic                    addr_err;
    logic [ADDR_WIDTH-1:0]   offset;
    logic [IDX_WIDTH-1:0]    setup_idx;
    logic                    done;
    logic [DATA_WIDTH-1:0]   rd_data;

    assign offset    = paddr - BASE_ADDR;
    assign setup_idx = IDX_WIDTH'(offset >> OFF_BITS);
    assign addr_err  = (paddr < BASE_ADDR)
                     || ({1'b0, paddr} >= END_ADDR)
                     || ((paddr & ALIGN_MASK) != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            write_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            write_reg <= write_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        write_next = write_reg;
        err_next   = err_reg;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                // An access phase with no preceding setup is a protocol violation and is ignored.
                if (psel && !penable) begin
                    state_next = ACCESS;
                    idx_next   = setup_idx;
                    write_next = pwrite;
                    cnt_next   = wait_cycles;
                    err_next   = addr_err;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_next = IDLE;
                end else if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - WAIT_WIDTH'(1);
                end else begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    uvmt_axil_st_rsp_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (done && write_reg && !err_reg),
        .waddr   (idx_reg),
        .wdata   (pwdata),
        .raddr   (idx_reg),
        .rdata   (rd_data)
    );

    assign pready  = done;
    assign pslverr = done && err_reg;
    assign prdata  = (done && !write_reg && !err_reg) ? rd_data : '0;

endmodule

// File: tb/tb_uvmt_axil_st_rsp_mem.sv
// Directed bench for the memory-backed bus responder.
module tb_uvmt_axil_st_rsp_mem;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int WW    = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [WW-1:0] wait_cycles = '0;
    logic [AW-1:0] paddr = '0;
    logic          psel = 1'b0;
    logic          penable = 1'b0;
    logic          pwrite = 1'b0;
    logic [DW-1:0] pwdata = '0;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;

    logic [DW-1:0] model [DEPTH];
    int            vec_cnt = 0;
    int            miss_cnt = 0;

    uvmt_axil_st_rsp_mem #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .BASE_ADDR  ('0),
        .WAIT_WIDTH (WW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wait_cycles (wait_cycles),
        .paddr       (paddr),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    // One full transfer; returns at the falling edge of the completion cycle.
    task automatic xfer(input string tag, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int wc, input logic exp_err);
        int            n;
        logic          seen;
        logic [DW-1:0] rd;
        logic          err;
        logic [DW-1:0] exp_rd;
        int            idx;
        idx = int'((a >> 2) & 32'hFF);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        wait_cycles = WW'(wc);
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0; seen = 1'b0; rd = '0; err = 1'b0;
        while (!seen && n < 32) begin
            @(negedge clk);
            n++;
            if (pready) begin
                seen = 1'b1;
                rd   = prdata;
                err  = pslverr;
            end
        end
        exp_rd = (!w && !exp_err) ? model[idx] : '0;
        check_eq({tag, ".lat"}, 64'(n), 64'(wc + 1));
        check_eq({tag, ".err"}, 64'(err), 64'(exp_err));
        check_eq({tag, ".rdata"}, 64'(rd), 64'(exp_rd));
        if (w && !exp_err) model[idx] = d;
        $display("xfer %s %s addr=%h wdata=%h wait=%0d lat=%0d rdata=%h err=%b",
                 tag, w ? "WR" : "RD", a, d, wc, n, rd, err);
    endtask

    initial begin
        clear_model();

        // Reset state
        #2;
        check_eq("rst.pready", 64'(pready), 64'd0);
        check_eq("rst.prdata", 64'(prdata), 64'd0);
        check_eq("rst.pslverr", 64'(pslverr), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;

        // 1: basic write/read, zero wait
        xfer("t1.wr", 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
        xfer("t1.rd", 1'b0, 32'h10, 32'h0, 0, 1'b0);
        go_idle();

        // 2: read with 3 wait states
        xfer("t2.rd", 1'b0, 32'h0, 32'h0, 3, 1'b0);
        go_idle();

        // 3: out-of-range and misaligned writes, then full sweep
        xfer("t3.oor", 1'b1, 32'h400, 32'h11111111, 0, 1'b1);
        xfer("t3.mis", 1'b1, 32'h2, 32'h22222222, 0, 1'b1);
        xfer("t3.oor_rd", 1'b0, 32'h400, 32'h0, 1, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            xfer($sformatf("t3.sweep%0d", i), 1'b0, 32'(i * 4), 32'h0, 0, 1'b0);
        end
        go_idle();

        // 4: aborted write
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h1234;
        wait_cycles = WW'(5);
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check_eq("t4.acc1", 64'(pready), 64'd0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check_eq("t4.acc2", 64'(pready), 64'd0);
        $display("xfer t4.abort WR addr=00000020 wdata=00001234 aborted");
        xfer("t4.rd", 1'b0, 32'h20, 32'h0, 0, 1'b0);
        go_idle();

        // Access phase without setup is ignored
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h24; pwdata = 32'h5555;
        @(negedge clk);
        check_eq("pv.c1", 64'(pready), 64'd0);
        @(negedge clk);
        check_eq("pv.c2", 64'(pready), 64'd0);
        $display("xfer pv WR addr=00000024 without setup ignored");
        go_idle();
        xfer("pv.rd", 1'b0, 32'h24, 32'h0, 0, 1'b0);

        // 5: write then immediate read, no idle gap
        xfer("t5.wr", 1'b1, 32'h3FC, 32'hA5A5A5A5, 0, 1'b0);
        xfer("t5.rd", 1'b0, 32'h3FC, 32'h0, 0, 1'b0);
        xfer("t5.rd10", 1'b0, 32'h10, 32'h0, 2, 1'b0);
        go_idle();

        // 6: reset in the 2nd wait cycle of a write
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30; pwdata = 32'hCAFEF00D;
        wait_cycles = WW'(3);
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check_eq("t6.pready", 64'(pready), 64'd0);
        check_eq("t6.prdata", 64'(prdata), 64'd0);
        clear_model();
        $display("xfer t6 WR addr=00000030 reset in wait cycle");
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        xfer("t6.rd10", 1'b0, 32'h10, 32'h0, 0, 1'b0);
        xfer("t6.rd3fc", 1'b0, 32'h3FC, 32'h0, 0, 1'b0);
        xfer("t6.rd30", 1'b0, 32'h30, 32'h0, 0, 1'b0);
        go_idle();

        // Reset during the completion cycle drops pready at once and discards the write
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h40; pwdata = 32'h0BADCAFE;
        wait_cycles = WW'(0);
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check_eq("t6b.pre", 64'(pready), 64'd1);
        reset_n = 1'b0;
        #1;
        check_eq("t6b.drop", 64'(pready), 64'd0);
        $display("xfer t6b WR addr=00000040 reset in completion cycle");
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        xfer("t6b.rd40", 1'b0, 32'h40, 32'h0, 0, 1'b0);
        go_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
